// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM states and default width.
package serial_subtractor_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

endpackage

// File: rtl/serial_subtractor_if.sv
// Request/result bundle between a requester (master) and the serial subtractor (slave).
interface serial_subtractor_if
    import serial_subtractor_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
);

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;

    modport master (
        output start, a, b,
        input  busy, done, diff, bout
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, bout
    );

endinterface

// File: rtl/serial_subtractor_cell.sv
// One-bit full subtractor: diff = a - b - bin, bout set when the bit underflows.
module full_subtractor_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    assign diff = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a-b, LSB first, one bit per clock through a single full-subtractor cell.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_subtractor_if.slave bus
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic             load;
    logic             step;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] diff_reg;
    logic             borrow;
    logic [CW-1:0]    cnt;
    logic             cell_diff;
    logic             cell_bout;

    full_subtractor_cell u_cell (
        .a    (a_reg[0]),
        .b    (b_reg[0]),
        .bin  (borrow),
        .diff (cell_diff),
        .bout (cell_bout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    load      = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                step = 1'b1;
                if (cnt == LAST) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Result enters at the MSB so after WIDTH steps bit 0 lands at diff_reg[0].
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg    <= '0;
            b_reg    <= '0;
            diff_reg <= '0;
            borrow   <= 1'b0;
            cnt      <= '0;
        end else if (load) begin
            a_reg  <= bus.a;
            b_reg  <= bus.b;
            borrow <= 1'b0;
            cnt    <= '0;
        end else if (step) begin
            diff_reg <= {cell_diff, diff_reg[WIDTH-1:1]};
            borrow   <= cell_bout;
            a_reg    <= a_reg >> 1;
            b_reg    <= b_reg >> 1;
            cnt      <= cnt + CW'(1);
        end
    end

    assign bus.busy = (state != IDLE);
    assign bus.done = (state == DONE);
    assign bus.diff = diff_reg;
    assign bus.bout = borrow;

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request to begin a subtraction; sampled only in IDLE.
REQ-005 a  input  WIDTH  minuend, unsigned; captured on accepted start.
REQ-006 b  input  WIDTH  subtrahend, unsigned; captured on accepted start.
REQ-007 busy  output  1  high while an operation is in progress (SHIFT or DONE state).
REQ-008 done  output  1  one-cycle pulse; diff/bout are valid from this cycle on.
REQ-009 diff  output  WIDTH  result a-b modulo 2^WIDTH.
REQ-010 bout  output  1  final borrow; 1 iff a<b (unsigned).

Function
REQ-011 The block SHALL compute a-b bit-serially, LSB first, one bit per clock, using a single full-subtractor cell whose borrow-in comes from a registered borrow.
REQ-012 FSM states SHALL be IDLE, SHIFT, DONE; the reset state is IDLE.
REQ-013 IDLE: on an edge with start=1, the block SHALL load a and b into shift registers, clear the borrow register to 0, clear the bit counter to 0 and enter SHIFT.
REQ-014 SHIFT: each edge SHALL apply the current LSBs of the a/b registers and the borrow register to the cell, shift the cell's diff bit into the result register at the MSB end (right shift), store the cell's bout in the borrow register, shift the a/b registers right by one and increment the counter.
REQ-015 SHIFT SHALL last exactly WIDTH edges; on the edge processing counter value WIDTH-1 the FSM SHALL enter DONE.
REQ-016 DONE SHALL last exactly one cycle, with done=1, then return to IDLE unconditionally.
REQ-017 Latency: with start accepted at edge k, done SHALL be high during the cycle after edge k+WIDTH, i.e. WIDTH+1 cycles after the start cycle.
REQ-018 diff SHALL equal the full result register and bout the borrow register from DONE onward; both SHALL hold until the next accepted start.
REQ-019 During SHIFT, diff and bout SHALL NOT be used by consumers; their values are don't-care until done.
REQ-020 start while busy=1 (SHIFT or DONE) SHALL be ignored with no effect on the operation in progress.
REQ-021 Changes on a or b after the accepting edge SHALL NOT affect the result.
REQ-022 start held high continuously SHALL produce back-to-back operations, each accepted in the IDLE cycle following DONE, giving a WIDTH+2-cycle period.
REQ-023 busy SHALL be 1 in SHIFT and DONE and 0 in IDLE.

Reset
REQ-024 Asserting rst_n=0 SHALL asynchronously force: state IDLE, busy=0, done=0, diff=0, bout=0, counter=0, operand registers=0.
REQ-025 Reset asserted mid-operation SHALL abort the operation with no done pulse; after release the block SHALL accept a new start on the first edge.

Structure
REQ-026 A shared package SHALL hold the FSM state enumeration (IDLE/SHIFT/DONE) and the default WIDTH constant.
REQ-027 The one-bit full subtractor SHALL be a sub-module named full_subtractor_cell (inputs a, b, bin; outputs diff, bout; purely combinational); all sequencing stays in serial_subtractor.
REQ-028 The counter SHALL be $clog2(WIDTH)+1 bits wide so WIDTH=32 does not wrap early.

Verification
REQ-029 WIDTH=8, a=10, b=3, start one cycle -> done pulse exactly 9 cycles later, diff=7, bout=0.
REQ-030 a=3, b=10 -> diff=249, bout=1; a=0, b=0 -> diff=0, bout=0; a=255, b=255 -> diff=0, bout=0; a=0, b=1 -> diff=255, bout=1.
REQ-031 Start at cycle 0 with a=100, b=50, then pulse start at cycle 3 with a=1, b=2 -> single done, diff=50, bout=0.
REQ-032 start held high for 30 cycles with fixed a=200, b=201 -> done every 10 cycles, each diff=255, bout=1.
REQ-033 rst_n driven low at cycle 4 of an operation -> busy, done, diff, bout all 0 immediately; no done pulse; a following start with a=20, b=5 -> diff=15.
REQ-034 Randomised self-check over 1000 operand pairs at WIDTH=8 and WIDTH=32 -> diff and bout match a golden model of {bout,diff} = a-b.
